dcache_port_arbiter: RTL and testbench

Shares one in-order data-cache request port between `NrPorts` requesters: PTW, load unit and store/AMO unit. It sits between those units and the write-back dcache. Arbitration is round-robin, and a grant is locked until its handshake completes. Each issued request's requester index is recorded in a small FIFO so that cache responses are routed back in order. Issue is throttled to `MaxOutstanding` in-flight requests.

---
 rtl/dcache_arb_pkg.sv | 27 ++
 rtl/dcache_arb_tag_fifo.sv | 72 +++++++
 rtl/dcache_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_arb_pkg.sv
// Shared definitions for the data-cache port arbiter.
// Holds the requester index constants, the request payload struct and the
// index-width helper used by the arbiter and its tag FIFO.
package dcache_arb_pkg;

  localparam int unsigned NR_PORTS = 3;
  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned BE_W     = DATA_W / 8;

  localparam int unsigned PORT_PTW   = 0;
  localparam int unsigned PORT_LOAD  = 1;
  localparam int unsigned PORT_STORE = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } dcache_arb_req_t;

  // Width of an index into n items; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_arb_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each in-flight cache
// request so responses can be steered back in issue order.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, data_i     enqueue a requester index (ignored when full)
//   pop_i, data_o      dequeue / head index (pop ignored when empty)
//   full_o, empty_o    occupancy flags
//   count_o            number of stored entries
module dcache_arb_tag_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth+1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap explicitly so non-power-of-two depths work.
    if (do_push) wr_ptr_d = (wr_ptr_q == PtrW'(Depth-1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth-1)) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one in-order dcache request port between NrPorts requesters
// (0 = PTW, 1 = load, 2 = store/AMO). Round-robin arbitration with the grant
// locked until the handshake completes; a tag FIFO routes in-order responses
// back to their requester and caps in-flight requests at MaxOutstanding.
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o            per-requester handshake
//   req_addr_i/we/be/wdata             per-requester payload (packed per port)
//   rsp_valid_o, rsp_rdata_o           one-hot response strobe, broadcast data
//   cache_req_valid_o/ready_i          request handshake toward the cache
//   cache_addr/we/be/wdata_o           payload of the granted requester
//   cache_rsp_valid_i, rdata_i         in-order cache response
//   outstanding_o                      registered in-flight count
//   unexpected_rsp_o                   response seen while nothing in flight
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned NrPorts        = 3,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NrPorts-1:0]                  req_valid_i,
  output logic [NrPorts-1:0]                  req_ready_o,
  input  logic [NrPorts*AddrWidth-1:0]        req_addr_i,
  input  logic [NrPorts-1:0]                  req_we_i,
  input  logic [NrPorts*(DataWidth/8)-1:0]    req_be_i,
  input  logic [NrPorts*DataWidth-1:0]        req_wdata_i,
  output logic [NrPorts-1:0]                  rsp_valid_o,
  output logic [DataWidth-1:0]                rsp_rdata_o,
  output logic                                cache_req_valid_o,
  input  logic                                cache_req_ready_i,
  output logic [AddrWidth-1:0]                cache_addr_o,
  output logic                                cache_we_o,
  output logic [DataWidth/8-1:0]              cache_be_o,
  output logic [DataWidth-1:0]                cache_wdata_o,
  input  logic                                cache_rsp_valid_i,
  input  logic [DataWidth-1:0]                cache_rsp_rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                                unexpected_rsp_o
);

  localparam int unsigned IdxW = idx_width(NrPorts);
  localparam int unsigned BeW  = DataWidth / 8;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            locked_q, locked_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;

  logic [IdxW-1:0] rr_idx, cand, winner, head_idx;
  logic            found, any_valid, fifo_full, fifo_empty;
  logic            issue_en, hs, rsp_ok;
  dcache_arb_req_t sel_req;

  assign any_valid = |req_valid_i;

  // First valid requester at or after ptr, wrapping modulo NrPorts.
  always_comb begin
    rr_idx = ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < int'(NrPorts); i++) begin
      cand = IdxW'((int'(ptr_q) + i) % int'(NrPorts));
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        rr_idx = cand;
      end
    end
  end

  assign winner = locked_q ? lock_idx_q : rr_idx;

  // A full FIFO blocks issue even when a response pops this cycle, keeping
  // the response path out of the request path.
  assign issue_en = rst_ni & any_valid & ~fifo_full;
  assign hs       = issue_en & cache_req_ready_i;

  always_comb begin
    sel_req = '0;
    for (int p = 0; p < int'(NrPorts); p++) begin
      if (winner == IdxW'(p)) begin
        sel_req.addr  = req_addr_i[p*AddrWidth +: AddrWidth];
        sel_req.we    = req_we_i[p];
        sel_req.be    = req_be_i[p*BeW +: BeW];
        sel_req.wdata = req_wdata_i[p*DataWidth +: DataWidth];
      end
    end
  end

  assign cache_req_valid_o = issue_en;
  assign cache_addr_o      = sel_req.addr;
  assign cache_we_o        = sel_req.we;
  assign cache_be_o        = sel_req.be;
  assign cache_wdata_o     = sel_req.wdata;

  always_comb begin
    req_ready_o = '0;
    if (issue_en) req_ready_o[winner] = cache_req_ready_i;
  end

  // Responses: steer to the oldest tag; with no tag the beat is dropped.
  assign rsp_ok           = rst_ni & cache_rsp_valid_i & ~fifo_empty;
  assign unexpected_rsp_o = rst_ni & cache_rsp_valid_i & fifo_empty;
  assign rsp_rdata_o      = cache_rsp_rdata_i;

  always_comb begin
    rsp_valid_o = '0;
    if (rsp_ok) rsp_valid_o[head_idx] = 1'b1;
  end

  always_comb begin
    ptr_d      = ptr_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (hs) begin
      ptr_d    = (winner == IdxW'(NrPorts-1)) ? '0 : winner + 1'b1;
      locked_d = 1'b0;
    end else if (issue_en) begin
      locked_d   = 1'b1;
      lock_idx_d = winner;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  dcache_arb_tag_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .data_i  (winner),
    .pop_i   (rsp_ok),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  // A locked requester must hold its request until the handshake.
  a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    locked_q |-> req_valid_i[lock_idx_q]);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;
  import dcache_arb_pkg::*;

  localparam int NP = 3;

  logic              clk, rst_n;
  logic [NP-1:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [NP*64-1:0]  req_addr, req_wdata;
  logic [NP*8-1:0]   req_be;
  logic [63:0]       rsp_rdata, cache_addr, cache_wdata, cache_rdata;
  logic              cache_req_valid, cache_req_ready, cache_we, cache_rsp_valid;
  logic [7:0]        cache_be;
  logic [2:0]        outstanding;
  logic              unexpected;

  int n_vec = 0;
  int n_err = 0;

  dcache_port_arbiter dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_addr_i        (req_addr),
    .req_we_i          (req_we),
    .req_be_i          (req_be),
    .req_wdata_i       (req_wdata),
    .rsp_valid_o       (rsp_valid),
    .rsp_rdata_o       (rsp_rdata),
    .cache_req_valid_o (cache_req_valid),
    .cache_req_ready_i (cache_req_ready),
    .cache_addr_o      (cache_addr),
    .cache_we_o        (cache_we),
    .cache_be_o        (cache_be),
    .cache_wdata_o     (cache_wdata),
    .cache_rsp_valid_i (cache_rsp_valid),
    .cache_rsp_rdata_i (cache_rdata),
    .outstanding_o     (outstanding),
    .unexpected_rsp_o  (unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] p_addr(input int p);
    return 64'h0000_0000_8000_1000 + 64'(p) * 64'h100;
  endfunction
  function automatic logic [63:0] p_wdata(input int p);
    return 64'hDA7A_0000_0000_0000 | 64'(p);
  endfunction
  function automatic logic [7:0] p_be(input int p);
    return 8'h0F << p;
  endfunction

  typedef struct {
    logic [2:0]  vld;
    logic        crdy;
    logic        rspv;
    logic [63:0] rdata;
    logic        ecvld;
    logic [2:0]  erdy;
    int          eport;  // expected payload source, -1 = not checked
    logic [2:0]  ersp;
    logic [2:0]  eout;
    logic        eunx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] vld, input logic crdy, input logic rspv,
                              input logic [63:0] rdata, input logic ecvld, input logic [2:0] erdy,
                              input int eport, input logic [2:0] ersp, input logic [2:0] eout,
                              input logic eunx);
    vec_t v;
    v.vld = vld; v.crdy = crdy; v.rspv = rspv; v.rdata = rdata; v.ecvld = ecvld;
    v.erdy = erdy; v.eport = eport; v.ersp = ersp; v.eout = eout; v.eunx = eunx;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] vld, input logic crdy, input logic rspv,
                       input logic [63:0] rdata);
    req_valid       = vld;
    cache_req_ready = crdy;
    cache_rsp_valid = rspv;
    cache_rdata     = rdata;
  endtask

  task automatic chk_outputs(input string nm, input vec_t v);
    chk({nm, ".cvld"}, 64'(cache_req_valid), 64'(v.ecvld));
    chk({nm, ".rdy"},  64'(req_ready),       64'(v.erdy));
    chk({nm, ".rsp"},  64'(rsp_valid),       64'(v.ersp));
    chk({nm, ".out"},  64'(outstanding),     64'(v.eout));
    chk({nm, ".unx"},  64'(unexpected),      64'(v.eunx));
    if (v.eport >= 0) begin
      chk({nm, ".addr"},  cache_addr,       p_addr(v.eport));
      chk({nm, ".we"},    64'(cache_we),    64'(v.eport == PORT_STORE));
      chk({nm, ".be"},    64'(cache_be),    64'(p_be(v.eport)));
      chk({nm, ".wdata"}, cache_wdata,      p_wdata(v.eport));
    end
    if (v.ersp != 3'b000) chk({nm, ".rdata"}, rsp_rdata, v.rdata);
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      req_addr[p*64 +: 64]  = p_addr(p);
      req_wdata[p*64 +: 64] = p_wdata(p);
      req_be[p*8 +: 8]      = p_be(p);
      req_we[p]             = (p == PORT_STORE);
    end

    // Round robin with immediate responses.
    vecs.push_back(mk(3'b111, 1, 0, 64'h0,    1, 3'b001,  0, 3'b000, 3'd0, 0));
    vecs.push_back(mk(3'b111, 1, 1, 64'hA1,   1, 3'b010,  1, 3'b001, 3'd1, 0));
    vecs.push_back(mk(3'b111, 1, 1, 64'hA2,   1, 3'b100,  2, 3'b010, 3'd1, 0));
    vecs.push_back(mk(3'b000, 1, 1, 64'hA3,   0, 3'b000, -1, 3'b100, 3'd1, 0));
    // Response with nothing in flight, then the pulse clears.
    vecs.push_back(mk(3'b000, 1, 1, 64'hBAD,  0, 3'b000, -1, 3'b000, 3'd0, 1));
    vecs.push_back(mk(3'b000, 1, 0, 64'h0,    0, 3'b000, -1, 3'b000, 3'd0, 0));
    // Lock on port 1 while port 0 (favoured by ptr) joins.
    vecs.push_back(mk(3'b010, 0, 0, 64'h0,    1, 3'b000,  1, 3'b000, 3'd0, 0));
    vecs.push_back(mk(3'b011, 0, 0, 64'h0,    1, 3'b000,  1, 3'b000, 3'd0, 0));
    vecs.push_back(mk(3'b011, 0, 0, 64'h0,    1, 3'b000,  1, 3'b000, 3'd0, 0));
    vecs.push_back(mk(3'b011, 1, 0, 64'h0,    1, 3'b010,  1, 3'b000, 3'd0, 0));
    vecs.push_back(mk(3'b001, 1, 0, 64'h0,    1, 3'b001,  0, 3'b000, 3'd1, 0));
    // Count 2: push and pop together, response to oldest (port 1).
    vecs.push_back(mk(3'b100, 1, 1, 64'hB1,   1, 3'b100,  2, 3'b010, 3'd2, 0));
    vecs.push_back(mk(3'b000, 1, 0, 64'h0,    0, 3'b000, -1, 3'b000, 3'd2, 0));
    // Fill to four, fifth blocked even with a same-cycle response.
    vecs.push_back(mk(3'b001, 1, 0, 64'h0,    1, 3'b001,  0, 3'b000, 3'd2, 0));
    vecs.push_back(mk(3'b001, 1, 0, 64'h0,    1, 3'b001,  0, 3'b000, 3'd3, 0));
    vecs.push_back(mk(3'b001, 1, 1, 64'hC1,   0, 3'b000, -1, 3'b001, 3'd4, 0));
    vecs.push_back(mk(3'b001, 1, 0, 64'h0,    1, 3'b001,  0, 3'b000, 3'd3, 0));
    vecs.push_back(mk(3'b000, 1, 0, 64'h0,    0, 3'b000, -1, 3'b000, 3'd4, 0));
    // Drain in order: tags 2,0,0,0.
    vecs.push_back(mk(3'b000, 1, 1, 64'hC2,   0, 3'b000, -1, 3'b100, 3'd4, 0));
    vecs.push_back(mk(3'b000, 1, 1, 64'hC3,   0, 3'b000, -1, 3'b001, 3'd3, 0));
    vecs.push_back(mk(3'b000, 1, 1, 64'hC4,   0, 3'b000, -1, 3'b001, 3'd2, 0));
    vecs.push_back(mk(3'b000, 1, 1, 64'hC5,   0, 3'b000, -1, 3'b001, 3'd1, 0));
    vecs.push_back(mk(3'b000, 1, 0, 64'h0,    0, 3'b000, -1, 3'b000, 3'd0, 0));

    // Reset: outputs forced low even with live inputs.
    rst_n = 1'b0;
    drive(3'b111, 1, 1, 64'h55);
    #12;
    chk("rst.cvld", 64'(cache_req_valid), 64'd0);
    chk("rst.rdy",  64'(req_ready),       64'd0);
    chk("rst.rsp",  64'(rsp_valid),       64'd0);
    chk("rst.out",  64'(outstanding),     64'd0);
    chk("rst.unx",  64'(unexpected),      64'd0);
    drive(3'b000, 0, 0, 64'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].crdy, vecs[i].rspv, vecs[i].rdata);
      #2;
      chk_outputs($sformatf("v%0d", i), vecs[i]);
      @(posedge clk); #1;
    end

    // Two in flight, lock on port 2, then asynchronous reset mid-cycle.
    drive(3'b001, 1, 0, 64'h0); #2;
    chk("rs.a.rdy", 64'(req_ready), 64'b001);
    @(posedge clk); #1;
    drive(3'b010, 1, 0, 64'h0); #2;
    chk("rs.b.rdy", 64'(req_ready), 64'b010);
    @(posedge clk); #1;
    drive(3'b100, 0, 0, 64'h0); #2;
    chk("rs.c.addr", cache_addr, p_addr(2));
    @(posedge clk); #1;
    drive(3'b111, 0, 0, 64'h0); #2;
    chk("rs.d.addr", cache_addr, p_addr(2));
    chk("rs.d.out",  64'(outstanding), 64'd2);
    #1 rst_n = 1'b0;
    drive(3'b111, 1, 1, 64'h77); #1;
    chk("rs.cvld", 64'(cache_req_valid), 64'd0);
    chk("rs.rdy",  64'(req_ready),       64'd0);
    chk("rs.rsp",  64'(rsp_valid),       64'd0);
    chk("rs.out",  64'(outstanding),     64'd0);
    chk("rs.unx",  64'(unexpected),      64'd0);
    #1 rst_n = 1'b1;
    drive(3'b000, 0, 0, 64'h0);
    @(posedge clk); #1;
    // Late response for a discarded tag.
    drive(3'b000, 1, 1, 64'h99); #2;
    chk("post.unx", 64'(unexpected),  64'd1);
    chk("post.rsp", 64'(rsp_valid),   64'd0);
    chk("post.out", 64'(outstanding), 64'd0);
    @(posedge clk); #1;
    // Pointer back at 0 and lock cleared: port 0 wins.
    drive(3'b111, 1, 0, 64'h0); #2;
    chk("post.rdy",  64'(req_ready), 64'b001);
    chk("post.addr", cache_addr,     p_addr(0));
    chk("post.unx2", 64'(unexpected), 64'd0);
    @(posedge clk); #1;
    drive(3'b000, 0, 0, 64'h0); #2;
    chk("post.out1", 64'(outstanding), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
